// File: rtl/tmds_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tmds_pkg
// Brief    : Shared TMDS control tokens, receiver FSM state type and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package tmds_pkg;

  localparam logic [9:0] TOKEN_CD0 = 10'b1101010100;
  localparam logic [9:0] TOKEN_CD1 = 10'b0010101011;
  localparam logic [9:0] TOKEN_CD2 = 10'b0101010100;
  localparam logic [9:0] TOKEN_CD3 = 10'b1010101011;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] cd;
  } token_match_t;

  // Used by both the decoder and the encoder bench, so keep it standalone.
  function automatic logic [9:0] cd_to_token(input logic [1:0] cd);
    logic [9:0] tok;
    case (cd)
      2'b00:   tok = TOKEN_CD0;
      2'b01:   tok = TOKEN_CD1;
      2'b10:   tok = TOKEN_CD2;
      default: tok = TOKEN_CD3;
    endcase
    return tok;
  endfunction

  function automatic token_match_t match_token(input logic [9:0] word);
    token_match_t m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      if (word == cd_to_token(2'(i))) begin
        m.hit = 1'b1;
        m.cd  = 2'(i);
      end
    end
    return m;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage : tmds_pkg
`default_nettype wire

// File: rtl/tmds_word_aligner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tmds_word_aligner
// Brief    : Holds the previous raw word and registers the 10-bit window
//            selected by the current bit-slip offset.
// Revision : 1.0 - initial release
// ============================================================================
module tmds_word_aligner (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] tmds_in,
  input  logic [3:0] offset,
  output logic [9:0] aw
);

  logic [9:0]  prev_q;
  logic [19:0] cat;
  logic [9:0]  sel;

  // Offset k takes bits [19-k:10-k]; out-of-range offsets fall back to k=0.
  always_comb begin
    cat = {tmds_in, prev_q};
    sel = cat[19:10];
    for (int k = 1; k < 10; k++) begin
      if (offset == 4'(k)) begin
        sel = cat[(10 - k) +: 10];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      aw     <= '0;
    end else begin
      prev_q <= tmds_in;
      aw     <= sel;
    end
  end

endmodule : tmds_word_aligner
`default_nettype wire

// File: rtl/tmds_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tmds_decoder
// Brief    : TMDS channel receiver: word alignment by control-token search,
//            lock tracking and 10b->8b decode. Optional error counter of
//            lock losses enabled by TMDS_DECODER_ERRCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned TOKEN_RUN     = 4,
  parameter int unsigned SEARCH_CYCLES = 2048,
  parameter int unsigned LOSS_CYCLES   = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  tmds_in,
  output logic [7:0]  VD,
  output logic [1:0]  CD,
  output logic        VDE,
  output logic        locked,
  output logic [3:0]  offset
`ifdef TMDS_DECODER_ERRCNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam logic [15:0] RUN_TARGET  = 16'(TOKEN_RUN);
  localparam logic [15:0] SLIP_AT     = 16'(SEARCH_CYCLES - 1);
  localparam logic [15:0] LOSS_TARGET = 16'(LOSS_CYCLES);

  state_t       state;
  logic [15:0]  run_cnt;
  logic [15:0]  srch_cnt;
  logic [15:0]  loss_cnt;
  logic         skip;
  logic [9:0]   aw;

  token_match_t tok;
  logic         tok_hit;
  logic [15:0]  run_inc;
  logic [15:0]  loss_inc;
  logic         lock_due;
  logic         slip_due;
  logic         lose_lock;
  logic [7:0]   d_word;
  logic [7:0]   d_xor;
  logic [7:0]   vd_dec;

  tmds_word_aligner u_aligner (
    .clk     (clk),
    .rst     (rst),
    .tmds_in (tmds_in),
    .offset  (offset),
    .aw      (aw)
  );

  // The word straight after a slip was framed at the old offset; never count it.
  assign tok       = match_token(aw);
  assign tok_hit   = tok.hit & ~skip;
  assign run_inc   = sat_inc(run_cnt);
  assign loss_inc  = sat_inc(loss_cnt);
  assign lock_due  = (state == SEARCH) && tok_hit && (run_inc >= RUN_TARGET);
  assign slip_due  = (state == SEARCH) && (srch_cnt >= SLIP_AT);
  assign lose_lock = (state == LOCKED) && !tok_hit && (loss_inc >= LOSS_TARGET);

  always_comb begin
    d_word = aw[9] ? ~aw[7:0] : aw[7:0];
    d_xor  = d_word ^ {d_word[6:0], 1'b0};
    vd_dec = aw[8] ? d_xor : {~d_xor[7:1], d_xor[0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SEARCH;
      run_cnt  <= '0;
      srch_cnt <= '0;
      loss_cnt <= '0;
      skip     <= 1'b0;
      offset   <= '0;
      locked   <= 1'b0;
      VD       <= '0;
      CD       <= '0;
      VDE      <= 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          VD       <= '0;
          CD       <= '0;
          VDE      <= 1'b0;
          loss_cnt <= '0;
          skip     <= 1'b0;
          // Lock takes priority over a slip due on the same edge.
          if (lock_due) begin
            state    <= LOCKED;
            locked   <= 1'b1;
            run_cnt  <= '0;
            srch_cnt <= '0;
          end else if (slip_due) begin
            offset   <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
            srch_cnt <= '0;
            run_cnt  <= '0;
            skip     <= 1'b1;
          end else begin
            srch_cnt <= sat_inc(srch_cnt);
            run_cnt  <= tok_hit ? run_inc : 16'd0;
          end
        end

        LOCKED: begin
          skip <= 1'b0;
          if (tok_hit) begin
            VD       <= '0;
            CD       <= tok.cd;
            VDE      <= 1'b0;
            loss_cnt <= '0;
          end else begin
            VD  <= vd_dec;
            VDE <= 1'b1;
            if (lose_lock) begin
              // Offset is kept so the last good alignment is retried first.
              state    <= SEARCH;
              locked   <= 1'b0;
              loss_cnt <= '0;
              run_cnt  <= '0;
              srch_cnt <= '0;
            end else begin
              loss_cnt <= loss_inc;
            end
          end
        end

        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef TMDS_DECODER_ERRCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (lose_lock) begin
      err_cnt <= sat_inc(err_cnt);
    end
  end
`endif

endmodule : tmds_decoder
`default_nettype wire

// File: tb/tb_tmds_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tmds_decoder
// Brief    : Self-checking bench for tmds_decoder with a cycle-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tmds_decoder;

  localparam int TR = 4;
  localparam int S  = 8;
  localparam int L  = 40;

  localparam logic [9:0] T0 = 10'b1101010100;
  localparam logic [9:0] T1 = 10'b0010101011;
  localparam logic [9:0] T2 = 10'b0101010100;
  localparam logic [9:0] T3 = 10'b1010101011;

  logic       clk;
  logic       rst;
  logic [9:0] tmds_in;
  logic [7:0] VD;
  logic [1:0] CD;
  logic       VDE;
  logic       locked;
  logic [3:0] offset;
`ifdef TMDS_DECODER_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  tmds_decoder #(
    .TOKEN_RUN     (TR),
    .SEARCH_CYCLES (S),
    .LOSS_CYCLES   (L)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tmds_in (tmds_in),
    .VD      (VD),
    .CD      (CD),
    .VDE     (VDE),
    .locked  (locked),
    .offset  (offset)
`ifdef TMDS_DECODER_ERRCNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit cmp_en   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] tok_of(input int cd);
    case (cd)
      0:       return T0;
      1:       return T1;
      2:       return T2;
      default: return T3;
    endcase
  endfunction

  function automatic bit is_tok(input logic [9:0] w, output int cd);
    cd = 0;
    for (int i = 0; i < 4; i++) if (w == tok_of(i)) begin cd = i; return 1'b1; end
    return 1'b0;
  endfunction

  // Bit b of the window at slip k is serial bit (b + 10 - k) of {cur, prv}.
  function automatic logic [9:0] m_align(input logic [9:0] cur, input logic [9:0] prv, input int k);
    logic [9:0] r;
    for (int b = 0; b < 10; b++) begin
      int s;
      s = b + 10 - k;
      r[b] = (s >= 10) ? cur[s - 10] : prv[s];
    end
    return r;
  endfunction

  function automatic logic [7:0] m_decode(input logic [9:0] w);
    logic [7:0] d, v;
    for (int i = 0; i < 8; i++) d[i] = w[9] ? ~w[i] : w[i];
    v[0] = d[0];
    for (int i = 1; i < 8; i++) v[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return v;
  endfunction

  function automatic logic [9:0] rot(input logic [9:0] t, input int k);
    logic [9:0] r;
    for (int j = 0; j < 10; j++) r[j] = t[(j + k) % 10];
    return r;
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    int cd;
    do w = 10'($urandom); while (is_tok(w, cd));
    return w;
  endfunction

  // Behavioural receiver model, evaluated once per clock edge.
  logic [9:0] m_prev, m_aw;
  logic [7:0] e_vd;
  logic [1:0] e_cd;
  logic       e_vde;
  bit         m_locked, m_skip;
  int         m_off, m_run, m_srch, m_loss, m_err;

  task automatic model_step();
    int cdv;
    bit tk;
    logic [9:0] nxt;
    if (rst) begin
      m_prev = '0; m_aw = '0; e_vd = '0; e_cd = '0; e_vde = 1'b0;
      m_locked = 0; m_skip = 0; m_off = 0; m_run = 0; m_srch = 0; m_loss = 0; m_err = 0;
      return;
    end
    tk  = is_tok(m_aw, cdv) && !m_skip;
    nxt = m_align(tmds_in, m_prev, m_off);
    m_skip = 0;
    if (m_locked) begin
      if (tk) begin
        e_vd = '0; e_vde = 1'b0; e_cd = 2'(cdv); m_loss = 0;
      end else begin
        e_vd = m_decode(m_aw); e_vde = 1'b1; m_loss++;
        if (m_loss >= L) begin
          m_locked = 0; m_loss = 0; m_run = 0; m_srch = 0;
          if (m_err < 65535) m_err++;
        end
      end
    end else begin
      e_vd = '0; e_vde = 1'b0; e_cd = '0;
      m_run = tk ? m_run + 1 : 0;
      if (m_run >= TR) begin
        m_locked = 1; m_run = 0; m_srch = 0;
      end else if (m_srch == S - 1) begin
        m_off = (m_off + 1) % 10; m_srch = 0; m_run = 0; m_skip = 1;
      end else begin
        m_srch++;
      end
    end
    m_aw   = nxt;
    m_prev = tmds_in;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      bit bad;
      checks++;
      bad = (VD !== e_vd) || (CD !== e_cd) || (VDE !== e_vde) ||
            (locked !== m_locked) || (offset !== 4'(m_off));
`ifdef TMDS_DECODER_ERRCNT_EN
      bad = bad || (err_cnt !== 16'(m_err));
`endif
      if (bad) begin
        failures++;
        $display("FAIL model_cycle t=%0t got VD=%h CD=%0d VDE=%b locked=%b offset=%0d expected VD=%h CD=%0d VDE=%b locked=%b offset=%0d",
                 $time, VD, CD, VDE, locked, offset, e_vd, e_cd, e_vde, m_locked, m_off);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_VD"}, 32'(VD), 32'h0);
    chk({tag, "_CD"}, 32'(CD), 32'h0);
    chk({tag, "_VDE"}, 32'(VDE), 32'h0);
    chk({tag, "_locked"}, 32'(locked), 32'h0);
    chk({tag, "_offset"}, 32'(offset), 32'h0);
  endtask

  initial begin
    int since, nchg, len, prev_off;
    int chg_t [8];
    bit got, found;
    logic [9:0] w;

    rst = 1'b1;
    tmds_in = '0;
    repeat (2) @(negedge clk);
    cmp_en = 1;
    check_zero("reset");

    // Lock at offset 0: token i is sampled on the posedge after iteration i.
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 4) chk("lock_not_yet", 32'(locked), 32'h0);
      if (i == 5) chk("lock_rise", 32'(locked), 32'h1);
      tmds_in = T0;
    end
    @(negedge clk); chk("tok_vde", 32'(VDE), 32'h0); chk("tok_cd", 32'(CD), 32'h0);
    tmds_in = 10'h100;
    @(negedge clk); tmds_in = 10'h2FF;
    @(negedge clk); chk("dec_100_vd", 32'(VD), 32'h00); chk("dec_100_vde", 32'(VDE), 32'h1);
    tmds_in = T2;
    @(negedge clk); chk("dec_2ff_vd", 32'(VD), 32'hFE);
    tmds_in = 10'h2FF;
    @(negedge clk); chk("tok2_vde", 32'(VDE), 32'h0); chk("tok2_cd", 32'(CD), 32'h2);
    tmds_in = 10'h100;
    @(negedge clk); chk("cd_hold", 32'(CD), 32'h2); chk("cd_hold_vd", 32'(VD), 32'hFE);

    // Asynchronous reset mid-cycle while locked.
    #2; rst = 1'b1;
    #1; check_zero("async_rst1");
    @(negedge clk); rst = 1'b0;

    // Relock, then random traffic with frequent tokens so lock is held.
    for (int i = 0; i < 6; i++) begin @(negedge clk); tmds_in = T0; end
    since = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (since >= 8 || $urandom_range(0, 5) == 0) begin
        tmds_in = tok_of(int'($urandom_range(0, 3))); since = 0;
      end else begin
        tmds_in = rand_data(); since++;
      end
    end
    chk("random_still_locked", 32'(locked), 32'h1);

    // Loss of lock: last token, then only data words.
    @(negedge clk); tmds_in = T0;
    for (int j = 1; j <= L + 2; j++) begin
      @(negedge clk);
      if (j == L + 1) chk("loss_hold", 32'(locked), 32'h1);
      if (j == L + 2) begin
        chk("loss_drop", 32'(locked), 32'h0);
        chk("loss_offset", 32'(offset), 32'h0);
`ifdef TMDS_DECODER_ERRCNT_EN
        chk("err_cnt_one", 32'(err_cnt), 32'h1);
`endif
      end
      tmds_in = rand_data();
    end

    // Bit-slip search: serial T1 stream seen with a 3-bit skew.
    tmds_in = rot(T1, 3);
    do_reset();
    prev_off = 0; nchg = 0; got = 0;
    for (int c = 0; c < 12 * S && !got; c++) begin
      @(negedge clk);
      if (int'(offset) != prev_off) begin
        if (nchg < 8) chg_t[nchg] = cyc;
        nchg++;
        prev_off = int'(offset);
      end
      if (locked) got = 1;
    end
    chk("skew_locked", 32'(got), 32'h1);
    chk("skew_offset", 32'(offset), 32'h3);
    chk("skew_steps", 32'(nchg), 32'h3);
    if (nchg >= 3) begin
      chk("skew_interval_a", 32'(chg_t[1] - chg_t[0]), 32'(S));
      chk("skew_interval_b", 32'(chg_t[2] - chg_t[1]), 32'(S));
    end
    repeat (2) @(negedge clk);
    chk("skew_cd", 32'(CD), 32'h1);
    chk("skew_vde", 32'(VDE), 32'h0);

    // Slip/lock collision: the 4th token lands on the slip-due edge.
    tmds_in = '0;
    do_reset();
    found = 0;
    for (int c = 0; c < 4 * S && !found; c++) begin
      @(negedge clk);
      if (offset == 4'd1) found = 1;
    end
    chk("coll_first_slip", 32'(found), 32'h1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 7) chk("coll_not_yet", 32'(locked), 32'h0);
      if (k == 8) begin
        chk("coll_locked", 32'(locked), 32'h1);
        chk("coll_offset", 32'(offset), 32'h1);
      end
      tmds_in = (k >= 2) ? rot(T1, 1) : 10'h000;
    end
    @(negedge clk);

    // Asynchronous reset mid-cycle while locked at a non-zero offset.
    #2; rst = 1'b1;
    #1; check_zero("async_rst2");
    @(negedge clk); rst = 1'b0;

    // Random search-mode traffic with aligned token bursts at random skews.
    for (int n = 0; n < 3000; n += len) begin
      if ($urandom_range(0, 2) == 0) begin
        w = rot(tok_of(int'($urandom_range(0, 3))), int'($urandom_range(0, 9)));
        len = int'($urandom_range(4, 100));
        for (int j = 0; j < len; j++) begin @(negedge clk); tmds_in = w; end
      end else begin
        len = int'($urandom_range(1, 60));
        for (int j = 0; j < len; j++) begin @(negedge clk); tmds_in = 10'($urandom); end
      end
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_tmds_decoder
`default_nettype wire
